// File: rtl/memu_pkg.sv
// Shared types for the MEM stage: bus layouts, FSM states, mem_op encodings.
// Optional build macro used by memu: MEMU_MISALIGN_TRAP_EN.
package memu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} mem_state_e;

    // Loads and stores share the funct3-style encoding space.
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;
    localparam logic [2:0] MEM_SB  = 3'b000;
    localparam logic [2:0] MEM_SH  = 3'b001;
    localparam logic [2:0] MEM_SW  = 3'b010;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_4;
        logic            reg_wen;
        logic [1:0]      reg_wb_sel;
        logic [4:0]      reg_waddr;
        logic [XLEN-1:0] alu_out;
        logic            mem_ren;
        logic            mem_wen;
        logic [2:0]      mem_op;
        logic [XLEN-1:0] store_data;
        logic            branch_taken;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_4;
        logic            reg_wen;
        logic [1:0]      reg_wb_sel;
        logic [4:0]      reg_waddr;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] mem_out;
        logic            branch_taken;
    } mem_wb_t;

    localparam int unsigned EX_MEM_BUS_WIDTH = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_BUS_WIDTH = $bits(mem_wb_t);

    function automatic logic is_misaligned(input ex_mem_t b);
        logic half_bad;
        logic word_bad;
        half_bad = (b.mem_op[1:0] == 2'b01) && b.alu_out[0];
        word_bad = (b.mem_op[1:0] == 2'b10) && (b.alu_out[1:0] != 2'b00);
        return (b.mem_ren || b.mem_wen) && (half_bad || word_bad);
    endfunction

endpackage

// File: rtl/memu_align.sv
// Combinational lane logic: load byte/half extraction with extension, store
// replication and byte-strobe generation.
module memu_align
    import memu_pkg::*;
(
    input  logic [2:0]      mem_op,
    input  logic [1:0]      addr_lo,
    input  logic            is_store,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      wmask
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (mem_op)
            MEM_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LH:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LW:  load_data = rdata;
            MEM_LBU: load_data = {24'd0, shifted[7:0]};
            MEM_LHU: load_data = {16'd0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        wdata = store_data;
        wmask = 4'b0000;
        case (mem_op)
            MEM_SB: begin
                wdata = {4{store_data[7:0]}};
                wmask = 4'b0001 << addr_lo;
            end
            MEM_SH: begin
                wdata = {2{store_data[15:0]}};
                wmask = 4'b0011 << addr_lo;
            end
            MEM_SW: wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
        if (!is_store) begin
            wmask = 4'b0000;
        end
    end

endmodule

// File: rtl/memu.sv
// MEM pipeline stage: valid/ready stage register plus a request/response FSM.
// Build macro MEMU_MISALIGN_TRAP_EN turns misaligned accesses into a flagged no-op.
module memu
    import memu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [EX_MEM_BUS_WIDTH-1:0] ex_mem_bus,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [MEM_WB_BUS_WIDTH-1:0] mem_wb_bus,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [4:0]                  ex_mem_reg_waddr,
    output logic                        ex_mem_reg_wen,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    output logic                        mem_req_wen,
    output logic [DATA_WIDTH-1:0]       mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]     mem_req_wmask,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]       mem_rsp_rdata,
    output logic                        misalign_err
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;

    ex_mem_t         in_bus;
    ex_mem_t         stage_q;
    logic            pipe_valid_q;
    mem_state_e      state_q, state_d;
    logic [XLEN-1:0] mem_out_q;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wmask;
    logic            ready_go;
    logic            capture;
    logic            in_trap;
    logic            in_needs_mem;
    mem_wb_t         wb;

    assign in_bus   = ex_mem_t'(ex_mem_bus);
    assign ready_go = (state_q == StDone);
    assign s_ready  = ~pipe_valid_q | (m_ready & ready_go);
    assign m_valid  = pipe_valid_q & ready_go;
    assign capture  = s_valid & s_ready;

`ifdef MEMU_MISALIGN_TRAP_EN
    assign in_trap      = is_misaligned(in_bus);
    assign misalign_err = pipe_valid_q & ready_go & is_misaligned(stage_q);
`else
    assign in_trap      = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // A trapped access completes without touching memory.
    assign in_needs_mem = (in_bus.mem_ren | in_bus.mem_wen) & ~in_trap;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (capture) state_d = in_needs_mem ? StReq : StDone;
            end
            StReq: begin
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (mem_rsp_valid) state_d = StDone;
            end
            StDone: begin
                if (m_ready) begin
                    if (capture) state_d = in_needs_mem ? StReq : StDone;
                    else         state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= 1'b0;
            stage_q      <= '0;
            state_q      <= StIdle;
            mem_out_q    <= '0;
        end else begin
            state_q <= state_d;
            if (s_ready) pipe_valid_q <= s_valid;
            if (capture) begin
                stage_q   <= in_bus;
                mem_out_q <= '0;
            end else if (state_q == StWait && mem_rsp_valid && stage_q.mem_ren) begin
                mem_out_q <= load_data;
            end
        end
    end

    memu_align u_align (
        .mem_op     (stage_q.mem_op),
        .addr_lo    (stage_q.alu_out[1:0]),
        .is_store   (stage_q.mem_wen),
        .rdata      (XLEN'(mem_rsp_rdata)),
        .store_data (stage_q.store_data),
        .load_data  (load_data),
        .wdata      (wdata),
        .wmask      (wmask)
    );

    // Request fields come straight from the stage register, so they cannot
    // change while the request waits for acceptance.
    assign mem_req_valid = (state_q == StReq);
    assign mem_req_addr  = ADDR_WIDTH'(stage_q.alu_out);
    assign mem_req_wen   = stage_q.mem_wen;
    assign mem_req_wdata = DATA_WIDTH'(wdata);
    assign mem_req_wmask = StrbW'(wmask);

    assign ex_mem_reg_waddr = pipe_valid_q ? stage_q.reg_waddr : 5'd0;
    assign ex_mem_reg_wen   = pipe_valid_q & stage_q.reg_wen;

    always_comb begin
        wb.pc           = stage_q.pc;
        wb.instr        = stage_q.instr;
        wb.pc_4         = stage_q.pc_4;
        wb.reg_wen      = stage_q.reg_wen;
        wb.reg_wb_sel   = stage_q.reg_wb_sel;
        wb.reg_waddr    = stage_q.reg_waddr;
        wb.alu_out      = stage_q.alu_out;
        wb.mem_out      = mem_out_q;
        wb.branch_taken = stage_q.branch_taken;
    end

    assign mem_wb_bus = wb;

endmodule

// File: doc/memu.md
MEMU -- requirements
Module: memu

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, data path width.
- ADDR_WIDTH, 32, memory address width.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset: reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_mem_bus  in  EX_MEM_BUS_WIDTH  {PC, Instr, PC_4, reg_wen, reg_wb_sel, reg_waddr, alu_out, mem_ren, mem_wen, mem_op[2:0], store_data, branch_taken}
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- mem_wb_bus  out  MEM_WB_BUS_WIDTH  {PC, Instr, PC_4, reg_wen, reg_wb_sel, reg_waddr, alu_out, mem_out, branch_taken}
- m_valid  out  1  downstream valid
- m_ready  in  1  downstream ready
- ex_mem_reg_waddr  out  5  forwarding destination; 0 when stage empty
- ex_mem_reg_wen  out  1  forwarding write enable; 0 when stage empty
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accept
- mem_req_addr  out  ADDR_WIDTH  byte address (alu_out)
- mem_req_wen  out  1  1 = store, 0 = load
- mem_req_wdata  out  DATA_WIDTH  lane-shifted store data
- mem_req_wmask  out  DATA_WIDTH/8  byte strobes
- mem_rsp_valid  in  1  response valid (load data or store ack)
- mem_rsp_rdata  in  DATA_WIDTH  raw word read data
- misalign_err  out  1  misaligned-access flag

Function
REQ-003 The stage register SHALL capture ex_mem_bus only on s_valid && s_ready; pipe_is_valid SHALL load s_valid whenever s_ready is high.
REQ-004 s_ready SHALL equal ~pipe_is_valid || (m_ready && ready_go); m_valid SHALL equal pipe_is_valid && ready_go.
REQ-005 FSM states: IDLE, REQ, WAIT, DONE.
- IDLE->REQ on capture with mem_ren|mem_wen.
- IDLE->DONE on capture without memory access.
- REQ->WAIT on mem_req_ready.
- WAIT->DONE on mem_rsp_valid.
- DONE->REQ/DONE/IDLE on m_ready, per the next capture; otherwise DONE holds.
REQ-006 ready_go SHALL be 1 only in DONE, so latency from capture is 1 cycle for non-memory instructions and at least 3 cycles for memory instructions.
REQ-007 mem_req_valid SHALL be high only in REQ; address, wen, wdata and wmask SHALL stay stable until accepted.
REQ-008 mem_rsp_valid SHALL be ignored outside WAIT; a response in the same cycle as request acceptance is not legal.
REQ-009 mem_out SHALL be registered on the response: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word; the lane is selected by alu_out[1:0]. mem_out SHALL be 0 for non-loads.
REQ-010 Store data: SB replicates byte, mask 1<<a[1:0]; SH replicates half, mask 3<<a[1:0]; SW mask 4'hF.
REQ-011 When m_ready is low in DONE, mem_wb_bus and mem_out SHALL hold unchanged.
REQ-012 Back-to-back transfers (capture in the same cycle as hand-off) SHALL incur no bubble.

Reset
REQ-013 On rst: pipe_is_valid=0, stage register=0, FSM=IDLE, mem_out=0, and m_valid, mem_req_valid and misalign_err are 0.
REQ-014 Reset mid-transaction SHALL abandon the access; a late mem_rsp_valid arriving in IDLE SHALL be ignored.

Configuration
REQ-015 Macro MEMU_MISALIGN_TRAP_EN defined: a halfword access with a[0]=1, or a word access with a[1:0]!=0, SHALL skip REQ/WAIT and go straight to DONE with mem_out=0 and misalign_err=1 while the instruction is in DONE.
REQ-016 Macro MEMU_MISALIGN_TRAP_EN undefined: misalign_err SHALL be tied to 0 and every access SHALL be issued as given.

Structure
REQ-017 memu_pkg SHALL hold the FSM state enum, the mem_op encodings (LB/LH/LW/LBU/LHU/SB/SH/SW), and EX_MEM_BUS_WIDTH/MEM_WB_BUS_WIDTH.
REQ-018 A combinational sub-module memu_align SHALL implement load extraction/extension and store shift/mask generation.

Verification
REQ-019 ALU instruction, m_ready=1: m_valid 1 cycle after capture; mem_out=0; alu_out passes through.
REQ-020 LB at 0x1003, rdata 0x80FF_0000: mem_out=0xFFFF_FF80. LHU at 0x1002, same data: mem_out=0x0000_80FF.
REQ-021 SB at 0x2001, store_data 0x12: wdata=0x1212_1212, wmask=4'b0010, wen=1.
REQ-022 Hold mem_req_ready=0 for 3 cycles, then m_ready=0 for 2 cycles: request fields stable while waiting; s_ready=0 and bus stable until m_ready rises.
REQ-023 Assert rst during WAIT, then mem_rsp_valid: FSM in IDLE, no m_valid, response ignored.
REQ-024 MEMU_MISALIGN_TRAP_EN with LW at 0x3002: no mem_req_valid; misalign_err=1 and m_valid=1 the next cycle.
